led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised successor to the board blinker: drives N_LEDS board LEDs from a
//  selectable pattern engine (binary count, rotate, bounce, optional breathe).
//  A prescaler derives a step tick from clk; patterns advance once per tick.
//  Sits at the top of each board demo, directly on the LED pins (active-low).
// PARAMETERS
//  CLK_FREQ_HZ  10000000  input clock frequency in Hz
//  STEP_HZ      4         pattern step rate; DIV = max(1, CLK_FREQ_HZ/STEP_HZ)
//  N_LEDS       8         number of LED outputs, >= 1
//  PWM_BITS     8         breathe duty/PWM counter width (used only with LED_BREATHE_EN)
// PORTS
//  clk     in   1        system clock
//  rst     in   1        synchronous reset, active-high
//  mode    in   2        pattern select: 0 count, 1 rotate, 2 bounce, 3 breathe
//  pause   in   1        1 = freeze prescaler and pattern
//  tick    out  1        one-cycle pulse on each pattern step (registered)
//  leds    out  N_LEDS   LED drive, active-low (leds = ~pat)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): presc=0, pat=0, pos=0, dir=up, duty=0, mode_q=0,
//   tick=0, leds=all 1 (all off). Reset mid-pattern aborts immediately.
//  Prescaler: presc counts 0..DIV-1, $clog2(DIV+1) bits; at DIV-1 wraps to 0 and
//   tick=1 next cycle. DIV=1 -> tick high every cycle. pause=1: presc and all
//   pattern state hold, tick=0; release resumes from held count.
//  Mode latch: mode sampled only on tick cycles. If mode != mode_q at a tick,
//   mode_q<=mode and pattern loads that mode's initial value (no step that tick).
//   Initials: count pat=0; rotate pat=1; bounce pos=0,dir=up; breathe duty=0,up.
//  Step on tick (mode unchanged), pattern latency 1 cycle after tick:
//   0 count : pat <= pat+1, N_LEDS-bit wrap (all-ones -> 0).
//   1 rotate: pat <= {pat[N-2:0],pat[N-1]} (one-hot left rotate, MSB->bit0).
//   2 bounce: pat = one-hot at pos. dir up: pos++ until N_LEDS-1, then dir=down;
//            dir down: pos-- until 0, then dir=up. Reversal occurs on the tick
//            that reaches the end (ends shown one step each). N_LEDS=1: pos=0.
//   3 breathe: see CONFIGURATION.
//  Outputs registered; leds change exactly 1 cycle after the tick pulse cycle.
//  mode/pause are synchronous inputs; no synchroniser inside.
// CONFIGURATION
//  LED_BREATHE_EN defined:
//   - free-running pwm_cnt (PWM_BITS) increments every clk, wraps; not paused.
//   - per tick duty steps +1 while up; at 2^PWM_BITS-1 turns down; at 0 turns up.
//   - all LEDs lit (pat all 1) when pwm_cnt < duty, else off; duty=0 -> always off.
//  LED_BREATHE_EN undefined: no PWM logic; mode 3 behaves exactly as mode 0
//   (binary count), mode_q still records 3.
// TESTING (CLK_FREQ_HZ=16, STEP_HZ=4 -> DIV=4, N_LEDS=4, PWM_BITS=3)
//  - rst 2 cycles, mode=0 -> leds=4'hF during/after reset; tick every 4 clks;
//    after 16 ticks leds returns to 4'hF (count wrapped 15->0).
//  - mode=1 from reset -> first tick loads pat=0001 (leds=1110), then
//    0010,0100,1000,0001 on successive ticks.
//  - mode=2 -> pos sequence 0,1,2,3,2,1,0,1 over 8 ticks; N_LEDS=1 build stays 0001.
//  - pause=1 for 20 clks mid-count -> no tick, leds constant; resumes at held presc.
//  - rst asserted between ticks in mode 2 at pos=2 -> next cycle leds=4'hF,
//    mode_q=0, presc=0.
//  - LED_BREATHE_EN, mode=3, duty=4 -> leds low for 4 of every 8 clks; without
//    macro mode=3 steps like count.

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: pattern select/pause in, step tick and active-low LED drive out
// Signals: mode[1:0] pattern select, pause freeze, tick step pulse, leds[N_LEDS-1:0] active-low drive.
// Modports: master drives mode/pause (board/controller side), slave is the generator.
interface led_pattern_gen_if #(
  parameter int N_LEDS = 8
);
  logic [1:0] mode;
  logic pause;
  logic tick;
  logic [N_LEDS-1:0] leds;
  modport master(output mode, pause, input tick, leds);
  modport slave(input mode, pause, output tick, leds);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern engine (count, rotate, bounce, optional breathe)
// Ports: clk system clock; rst synchronous active-high reset;
//   bus.mode pattern select (0 count, 1 rotate, 2 bounce, 3 breathe); bus.pause freezes prescaler and pattern;
//   bus.tick registered one-cycle step pulse; bus.leds active-low LED drive (~pattern).
// Define LED_BREATHE_EN to build the PWM breathe engine; otherwise mode 3 counts like mode 0.
module led_pattern_gen #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int STEP_HZ = 4,
  parameter int N_LEDS = 8,
  parameter int PWM_BITS = 8
) (
  input logic clk,
  input logic rst,
  led_pattern_gen_if.slave bus
);
  localparam int DIV = (CLK_FREQ_HZ / STEP_HZ < 1) ? 1 : CLK_FREQ_HZ / STEP_HZ;
  localparam int CW = $clog2(DIV + 1);
  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  if (N_LEDS < 1 || PWM_BITS < 1) begin : g_bad_params
    $error("led_pattern_gen: N_LEDS and PWM_BITS must be >= 1");
  end
  typedef enum logic [1:0] {M_COUNT, M_ROTATE, M_BOUNCE, M_BREATHE} mode_t;
  mode_t mode_q, mode_n, mode_in;
  logic [CW-1:0] presc;
  logic tick_q, step, wrap, dir, dir_n;
  logic [N_LEDS-1:0] pat, pat_n, disp_n, leds_q;
  logic [PW-1:0] pos, pos_n;
`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] pwm_cnt, duty, duty_n;
`endif
  assign mode_in = mode_t'(bus.mode);
  assign wrap = presc == CW'(DIV - 1);
  // a tick arriving while paused is dropped so the pattern stays frozen
  assign step = tick_q && !bus.pause;
  assign bus.tick = tick_q;
  assign bus.leds = leds_q;
  always_comb begin
    mode_n = mode_q;
    pat_n = pat;
    pos_n = pos;
    dir_n = dir;
`ifdef LED_BREATHE_EN
    duty_n = duty;
`endif
    if (step) begin
      if (mode_in != mode_q) begin
        mode_n = mode_in;
        pos_n = '0;
        dir_n = 1'b0;
        pat_n = (mode_in == M_ROTATE || mode_in == M_BOUNCE) ? N_LEDS'(1) : '0;
`ifdef LED_BREATHE_EN
        duty_n = '0;
`endif
      end else begin
        case (mode_q)
          M_ROTATE: pat_n = (pat << 1) | (pat >> (N_LEDS - 1));
          M_BOUNCE: begin
            // dir flips on the step that lands on an end, so each end is shown for one step
            pos_n = (N_LEDS == 1) ? '0 : dir ? pos - 1'b1 : pos + 1'b1;
            dir_n = (N_LEDS == 1) ? 1'b0 : dir ? (pos_n != '0) : (pos_n == PW'(N_LEDS - 1));
            pat_n = N_LEDS'(1) << pos_n;
          end
`ifdef LED_BREATHE_EN
          M_BREATHE: begin
            duty_n = dir ? duty - 1'b1 : duty + 1'b1;
            dir_n = dir ? (duty_n != '0) : (duty_n == '1);
          end
`endif
          default: pat_n = pat + N_LEDS'(1);
        endcase
      end
    end
`ifdef LED_BREATHE_EN
    disp_n = (mode_n == M_BREATHE) ? {N_LEDS{pwm_cnt < duty_n}} : pat_n;
`else
    disp_n = pat_n;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      tick_q <= 1'b0;
      mode_q <= M_COUNT;
      pat <= '0;
      pos <= '0;
      dir <= 1'b0;
      leds_q <= '1;
    end else begin
      if (!bus.pause) presc <= wrap ? '0 : presc + 1'b1;
      tick_q <= !bus.pause && wrap;
      mode_q <= mode_n;
      pat <= pat_n;
      pos <= pos_n;
      dir <= dir_n;
      leds_q <= ~disp_n;
    end
  end
`ifdef LED_BREATHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      duty <= duty_n;
    end
  end
`endif
endmodule
